// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: shares the single UART TX FIFO write port among the
// command echo, time report and sensor report requesters. Requests are latched
// in pending flags. Echo always wins. Time and sensor alternate through a
// round-robin pointer. Each message is streamed as ASCII, one byte per
// accepted FIFO write.
module uart_tx_scheduler #(
  parameter bit P_CRLF    = 1'b1,
  parameter bit P_ECHO_EN = 1'b1
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iEcho_Req,
  input  logic [7:0]  iEcho_Data,
  input  logic        iTime_Req,
  input  logic [23:0] iTime_Bcd,
  input  logic        iSns_Req,
  input  logic [11:0] iDist_Bcd,
  input  logic [7:0]  iTemp_Bcd,
  input  logic [7:0]  iHumi_Bcd,
  input  logic        iTx_Full,
  output logic        oTx_Push,
  output logic [7:0]  oTx_Data,
  output logic        oBusy,
  output logic [2:0]  oGrant,
  output logic        oDrop
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

  localparam logic [4:0] L_TIME_LAST = P_CRLF ? 5'd9  : 5'd7;
  localparam logic [4:0] L_SNS_LAST  = P_CRLF ? 5'd16 : 5'd14;

  logic [0:0] state_q;
  logic       pend_echo_q, pend_time_q, pend_sns_q;
  logic [7:0] echo_buf_q;
  logic       rr_q;          // 0: prefer time, 1: prefer sensor
  logic [2:0] grant_q;
  logic [4:0] idx_q;
  logic [27:0] msg_q;        // snapshot of the granted requester's data
  logic       drop_q;

  logic       echo_req;
  logic [2:0] grant_d;
  logic       start, clr_echo, push, done;
  logic [4:0] last_idx;
  logic [7:0] ch;

  function automatic logic [7:0] dig(input logic [3:0] n);
    return (n > 4'd9) ? 8'h3F : {4'h3, n};
  endfunction

  assign echo_req = iEcho_Req & P_ECHO_EN;

  // Arbitration: echo first, then time vs sensor by the round-robin pointer.
  always_comb begin
    grant_d = 3'b000;
    if (pend_echo_q)                    grant_d = 3'b001;
    else if (pend_time_q && pend_sns_q) grant_d = rr_q ? 3'b100 : 3'b010;
    else if (pend_time_q)               grant_d = 3'b010;
    else if (pend_sns_q)                grant_d = 3'b100;
  end

  assign start    = (state_q == S_IDLE) && (grant_d != 3'b000);
  assign clr_echo = start && grant_d[0];
  assign push     = (state_q == S_SEND) && !iTx_Full;

  // Index of the final byte of the message currently being sent.
  always_comb begin
    last_idx = 5'd0;
    if (grant_q[1]) last_idx = L_TIME_LAST;
    if (grant_q[2]) last_idx = L_SNS_LAST;
  end

  assign done = push && (idx_q == last_idx);

  // Character generator: the byte at position idx_q of the current message.
  always_comb begin
    ch = 8'h00;
    unique case (1'b1)
      grant_q[0]: ch = msg_q[7:0];
      grant_q[1]: begin
        case (idx_q)
          5'd0: ch = dig(msg_q[23:20]);
          5'd1: ch = dig(msg_q[19:16]);
          5'd2: ch = 8'h3A;
          5'd3: ch = dig(msg_q[15:12]);
          5'd4: ch = dig(msg_q[11:8]);
          5'd5: ch = 8'h3A;
          5'd6: ch = dig(msg_q[7:4]);
          5'd7: ch = dig(msg_q[3:0]);
          5'd8: ch = 8'h0D;
          5'd9: ch = 8'h0A;
          default: ch = 8'h00;
        endcase
      end
      grant_q[2]: begin
        case (idx_q)
          5'd0:  ch = 8'h44;
          5'd1:  ch = 8'h3D;
          5'd2:  ch = dig(msg_q[27:24]);
          5'd3:  ch = dig(msg_q[23:20]);
          5'd4:  ch = dig(msg_q[19:16]);
          5'd5:  ch = 8'h20;
          5'd6:  ch = 8'h54;
          5'd7:  ch = 8'h3D;
          5'd8:  ch = dig(msg_q[15:12]);
          5'd9:  ch = dig(msg_q[11:8]);
          5'd10: ch = 8'h20;
          5'd11: ch = 8'h48;
          5'd12: ch = 8'h3D;
          5'd13: ch = dig(msg_q[7:4]);
          5'd14: ch = dig(msg_q[3:0]);
          5'd15: ch = 8'h0D;
          5'd16: ch = 8'h0A;
          default: ch = 8'h00;
        endcase
      end
      default: ch = 8'h00;
    endcase
  end

  assign oTx_Push = push;
  assign oTx_Data = (state_q == S_SEND) ? ch : 8'h00;
  assign oBusy    = (state_q == S_SEND);
  assign oGrant   = grant_q;
  assign oDrop    = drop_q;

  // Pending flags, echo buffer and drop pulse. A request on the same edge as
  // its grant re-arms the flag; a fresh echo byte is accepted then because the
  // old one is being consumed by the grant.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      pend_echo_q <= 1'b0;
      pend_time_q <= 1'b0;
      pend_sns_q  <= 1'b0;
      echo_buf_q  <= 8'h00;
      drop_q      <= 1'b0;
    end else begin
      pend_echo_q <= (pend_echo_q & ~clr_echo) | echo_req;
      pend_time_q <= (pend_time_q & ~(start & grant_d[1])) | iTime_Req;
      pend_sns_q  <= (pend_sns_q  & ~(start & grant_d[2])) | iSns_Req;
      if (echo_req && (!pend_echo_q || clr_echo)) echo_buf_q <= iEcho_Data;
      drop_q      <= echo_req && pend_echo_q && !clr_echo;
    end
  end

  // Message FSM. The round-robin pointer only moves when time and sensor
  // actually contended, so an uncontested grant does not steal the turn.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q <= S_IDLE;
      grant_q <= 3'b000;
      idx_q   <= 5'd0;
      msg_q   <= 28'h0;
      rr_q    <= 1'b0;
    end else if (start) begin
      state_q <= S_SEND;
      grant_q <= grant_d;
      idx_q   <= 5'd0;
      if (grant_d[0])      msg_q <= {20'h0, echo_buf_q};
      else if (grant_d[1]) msg_q <= {4'h0, iTime_Bcd};
      else                 msg_q <= {iDist_Bcd, iTemp_Bcd, iHumi_Bcd};
      if (!grant_d[0] && pend_time_q && pend_sns_q) rr_q <= grant_d[1];
    end else if (done) begin
      state_q <= S_IDLE;
      grant_q <= 3'b000;
      idx_q   <= 5'd0;
    end else if (push) begin
      idx_q   <= idx_q + 5'd1;
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: every byte written to the TX FIFO is
// logged at the falling edge and compared against hand-written strings.
module tb_uart_tx_scheduler;

  logic        iClk = 1'b0;
  logic        iRst;
  logic        iEcho_Req, iTime_Req, iSns_Req, iTx_Full;
  logic [7:0]  iEcho_Data, iTemp_Bcd, iHumi_Bcd;
  logic [23:0] iTime_Bcd;
  logic [11:0] iDist_Bcd;
  logic        oTx_Push, oBusy, oDrop;
  logic [7:0]  oTx_Data;
  logic [2:0]  oGrant;

  uart_tx_scheduler #(.P_CRLF(1'b1), .P_ECHO_EN(1'b1)) dut (
    .iClk(iClk), .iRst(iRst),
    .iEcho_Req(iEcho_Req), .iEcho_Data(iEcho_Data),
    .iTime_Req(iTime_Req), .iTime_Bcd(iTime_Bcd),
    .iSns_Req(iSns_Req), .iDist_Bcd(iDist_Bcd),
    .iTemp_Bcd(iTemp_Bcd), .iHumi_Bcd(iHumi_Bcd),
    .iTx_Full(iTx_Full), .oTx_Push(oTx_Push), .oTx_Data(oTx_Data),
    .oBusy(oBusy), .oGrant(oGrant), .oDrop(oDrop)
  );

  always #5 iClk = ~iClk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int drops = 0;
  logic [7:0] log_q[$];
  int         log_t[$];

  logic [7:0] time_exp [10] = '{8'h31, 8'h32, 8'h3A, 8'h33, 8'h34, 8'h3A,
                                8'h35, 8'h36, 8'h0D, 8'h0A};
  // "D=123 T=2? H=60\r\n"
  logic [7:0] sns_exp [17] = '{8'h44, 8'h3D, 8'h31, 8'h32, 8'h33, 8'h20,
                               8'h54, 8'h3D, 8'h32, 8'h3F, 8'h20, 8'h48,
                               8'h3D, 8'h36, 8'h30, 8'h0D, 8'h0A};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge iClk) cyc++;

  always @(negedge iClk) begin
    if (oTx_Push) begin
      log_q.push_back(oTx_Data);
      log_t.push_back(cyc);
    end
    if (oDrop) drops++;
  end

  function automatic logic [7:0] lb(input int i);
    return (i < log_q.size()) ? log_q[i] : 8'hEE;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge iClk);
    #1;
  endtask

  task automatic clr_log();
    log_q.delete();
    log_t.delete();
    drops = 0;
  endtask

  // One-cycle request pulse; returns just after the edge that samples it.
  task automatic req(input bit e, input bit t, input bit s, input logic [7:0] d);
    @(posedge iClk); #1;
    iEcho_Req = e; iTime_Req = t; iSns_Req = s; iEcho_Data = d;
    @(posedge iClk); #1;
    iEcho_Req = 0; iTime_Req = 0; iSns_Req = 0;
  endtask

  task automatic wait_bytes(input int n, input string tag);
    int k;
    for (k = 0; k < 40; k++) begin
      @(negedge iClk); #1;
      if (log_q.size() >= n) break;
    end
    chk(tag, log_q.size(), n);
  endtask

  initial begin
    iRst = 1; iEcho_Req = 0; iTime_Req = 0; iSns_Req = 0; iTx_Full = 0;
    iEcho_Data = 0; iTime_Bcd = 24'h123456; iDist_Bcd = 12'h123;
    iTemp_Bcd = 8'h25; iHumi_Bcd = 8'h60;
    tick(2);
    @(negedge iClk);
    chk("rst_push", oTx_Push, 0);
    chk("rst_data", oTx_Data, 0);
    chk("rst_busy", oBusy, 0);
    chk("rst_grant", oGrant, 0);
    chk("rst_drop", oDrop, 0);
    @(posedge iClk); #1 iRst = 0;

    // T1: echo, first push two cycles after the request
    clr_log();
    req(1, 0, 0, 8'h75);
    @(negedge iClk);
    chk("t1_c1_push", oTx_Push, 0);
    @(negedge iClk);
    chk("t1_c2_push", oTx_Push, 1);
    chk("t1_c2_data", oTx_Data, 8'h75);
    chk("t1_c2_grant", oGrant, 3'b001);
    chk("t1_c2_busy", oBusy, 1);
    @(negedge iClk);
    chk("t1_c3_busy", oBusy, 0);
    chk("t1_c3_grant", oGrant, 0);
    tick(3);
    chk("t1_count", log_q.size(), 1);

    // T2: time report, 10 back-to-back pushes
    clr_log();
    req(0, 1, 0, 8'h00);
    tick(20);
    chk("t2_count", log_q.size(), 10);
    for (int i = 0; i < 10; i++) chk($sformatf("t2_b%0d", i), lb(i), time_exp[i]);
    if (log_t.size() == 10) chk("t2_consec", log_t[9] - log_t[0], 9);

    // T3: FIFO full stalls the third byte for three cycles
    clr_log();
    req(0, 1, 0, 8'h00);
    wait_bytes(2, "t3_wait");
    @(posedge iClk); #1 iTx_Full = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge iClk);
      chk($sformatf("t3_stall_push%0d", i), oTx_Push, 0);
      chk($sformatf("t3_stall_data%0d", i), oTx_Data, 8'h3A);
    end
    @(posedge iClk); #1 iTx_Full = 0;
    tick(20);
    chk("t3_count", log_q.size(), 10);
    for (int i = 0; i < 10; i++) chk($sformatf("t3_b%0d", i), lb(i), time_exp[i]);

    // T4: all three at once -> echo, time, sensor; then time+sensor -> sensor first
    clr_log();
    req(1, 1, 1, 8'hA5);
    tick(60);
    chk("t4_count", log_q.size(), 28);
    chk("t4_echo", lb(0), 8'hA5);
    chk("t4_time0", lb(1), 8'h31);
    chk("t4_time9", lb(10), 8'h0A);
    chk("t4_sns0", lb(11), 8'h44);
    clr_log();
    req(0, 1, 1, 8'h00);
    tick(60);
    chk("t4b_count", log_q.size(), 27);
    chk("t4b_sns0", lb(0), 8'h44);
    chk("t4b_time0", lb(17), 8'h31);

    // T5: two echoes during a sensor message -> one drop, first byte kept
    iTemp_Bcd = 8'h2A;
    clr_log();
    req(0, 0, 1, 8'h00);
    tick(3);
    req(1, 0, 0, 8'h41);
    tick(2);
    req(1, 0, 0, 8'h42);
    tick(40);
    chk("t5_drops", drops, 1);
    chk("t5_count", log_q.size(), 18);
    for (int i = 0; i < 17; i++) chk($sformatf("t5_b%0d", i), lb(i), sns_exp[i]);
    chk("t5_echo", lb(17), 8'h41);
    iTemp_Bcd = 8'h25;

    // T6: reset mid-message with a time request pending
    clr_log();
    req(0, 0, 1, 8'h00);
    req(0, 1, 0, 8'h00);
    wait_bytes(5, "t6_wait");
    iRst = 1;
    #1;
    chk("t6_push", oTx_Push, 0);
    chk("t6_busy", oBusy, 0);
    chk("t6_grant", oGrant, 0);
    tick(2);
    iRst = 0;
    tick(40);
    chk("t6_count", log_q.size(), 5);
    chk("t6_b4", lb(4), 8'h33);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
